// File: rtl/mips_ctrl_pkg.sv
// Shared control types for the multicycle MIPS datapath: the sequencer state
// encoding (also consumed by the instruction decoder) and the EXEC1 dispatch class.
package mips_ctrl_pkg;

    localparam int SEQ_STATE_W = 3;

    typedef enum logic [SEQ_STATE_W-1:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        EXEC1  = 3'd2,
        EXEC2  = 3'd3,
        MDWAIT = 3'd4,
        HALT   = 3'd7
    } seq_state_t;

    // EXEC1 dispatch classes, from highest to lowest priority.
    typedef enum logic [1:0] {
        CLS_LOAD   = 2'd0,
        CLS_STORE  = 2'd1,
        CLS_MULDIV = 2'd2,
        CLS_OTHER  = 2'd3
    } exec_class_t;

    function automatic exec_class_t classify(input logic is_load,
                                             input logic is_store,
                                             input logic is_muldiv);
        if (is_load)   return CLS_LOAD;
        if (is_store)  return CLS_STORE;
        if (is_muldiv) return CLS_MULDIV;
        return CLS_OTHER;
    endfunction

endpackage

// File: rtl/mips_stall_timer.sv
// Counts consecutive stalled memory-strobe cycles and latches a sticky bus
// fault once the stall reaches TIMEOUT_CYCLES; a zero limit disables it entirely.
module mips_stall_timer #(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic stall,
    output logic timeout,
    output logic bus_err
);

    localparam bit EN = (TIMEOUT_CYCLES != 0);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST = EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

    logic [CW-1:0] cnt;

    // Fires on the stalled cycle that brings the count up to TIMEOUT_CYCLES.
    assign timeout = EN && stall && (cnt == LAST);

    // A stalled strobe always holds the sequencer in place, so clearing on any
    // non-stalled cycle also covers every state change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            bus_err <= 1'b0;
        end else begin
            if (!EN || !stall || timeout) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (timeout) begin
                bus_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mips_multicycle_sequencer.sv
// Multicycle CPU control sequencer: FETCH/EXEC1/EXEC2 with waitrequest stalls,
// a fixed-length MULT/DIV wait phase, and an optional bus-timeout halt.
module mips_multicycle_sequencer
    import mips_ctrl_pkg::*;
#(
    parameter int MULDIV_LATENCY = 4,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int STATE_W        = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               waitrequest,
    input  logic               pc_zero,
    input  logic               is_load,
    input  logic               is_store,
    input  logic               is_muldiv,
    output logic [STATE_W-1:0] state,
    output logic               active,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_src,
    output logic               ir_load,
    output logic               cnt_en,
    output logic               wb_en,
    output logic               muldiv_start,
    output logic               muldiv_busy,
    output logic               bus_err
);

    localparam int MD_W = (MULDIV_LATENCY > 1) ? $clog2(MULDIV_LATENCY) : 1;

    seq_state_t      st;
    logic [MD_W-1:0] md_cnt;
    exec_class_t     cls;
    logic            stall;
    logic            timeout;

    assign cls    = classify(is_load, is_store, is_muldiv);
    assign stall  = (mem_read | mem_write) & waitrequest;
    assign state  = STATE_W'(st);
    assign active = (st != IDLE) && (st != HALT);

    mips_stall_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_stall_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .stall   (stall),
        .timeout (timeout),
        .bus_err (bus_err)
    );

    // Strobes depend only on state and the latched decode, never on
    // waitrequest, so they stay flat for the whole stall.
    always_comb begin
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_src      = 1'b0;
        ir_load      = 1'b0;
        cnt_en       = 1'b0;
        wb_en        = 1'b0;
        muldiv_start = 1'b0;
        muldiv_busy  = 1'b0;
        case (st)
            FETCH: begin
                if (!pc_zero) begin
                    mem_read = 1'b1;
                    mem_src  = 1'b1;
                    ir_load  = !waitrequest;
                end
            end
            EXEC1: begin
                case (cls)
                    CLS_LOAD:   mem_read = 1'b1;
                    CLS_STORE: begin
                        mem_write = 1'b1;
                        cnt_en    = !waitrequest;
                    end
                    CLS_MULDIV: muldiv_start = 1'b1;
                    default:    cnt_en = 1'b1;
                endcase
            end
            EXEC2: begin
                wb_en  = 1'b1;
                cnt_en = 1'b1;
            end
            MDWAIT: begin
                muldiv_busy = 1'b1;
                cnt_en      = (md_cnt == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st     <= IDLE;
            md_cnt <= '0;
        end else if (timeout) begin
            st <= HALT;
        end else begin
            case (st)
                IDLE:  st <= FETCH;
                FETCH: begin
                    if (pc_zero) begin
                        st <= HALT;
                    end else if (!waitrequest) begin
                        st <= EXEC1;
                    end
                end
                EXEC1: begin
                    case (cls)
                        CLS_LOAD:  if (!waitrequest) st <= EXEC2;
                        CLS_STORE: if (!waitrequest) st <= FETCH;
                        CLS_MULDIV: begin
                            md_cnt <= MD_W'(MULDIV_LATENCY - 1);
                            st     <= MDWAIT;
                        end
                        default:   st <= FETCH;
                    endcase
                end
                EXEC2:  st <= FETCH;
                MDWAIT: begin
                    if (md_cnt == '0) begin
                        st <= FETCH;
                    end else begin
                        md_cnt <= md_cnt - MD_W'(1);
                    end
                end
                HALT:    st <= HALT;
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_sequencer.sv
// Self-checking bench for mips_multicycle_sequencer: directed vector table,
// hand-written reset/timeout sequences and randomized instruction streams.
module tb_mips_multicycle_sequencer;

    localparam int MD_LAT = 4;
    localparam int TMO    = 8;
    localparam int W      = 13;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_EXEC1  = 3'd2;
    localparam logic [2:0] S_EXEC2  = 3'd3;
    localparam logic [2:0] S_MDWAIT = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd7;

    logic       clk;
    logic       reset_n;
    logic       waitrequest;
    logic       pc_zero;
    logic       is_load;
    logic       is_store;
    logic       is_muldiv;
    logic [2:0] state;
    logic       active;
    logic       mem_read;
    logic       mem_write;
    logic       mem_src;
    logic       ir_load;
    logic       cnt_en;
    logic       wb_en;
    logic       muldiv_start;
    logic       muldiv_busy;
    logic       bus_err;

    typedef struct packed {
        logic wr;
        logic pz;
        logic ld;
        logic st;
        logic md;
    } stim_t;

    typedef struct packed {
        logic [2:0] st;
        logic       act;
        logic       rd;
        logic       wt;
        logic       src;
        logic       ir;
        logic       cnt;
        logic       wb;
        logic       mds;
        logic       mdb;
        logic       err;
    } out_t;

    typedef struct {
        stim_t s;
        out_t  o;
    } vec_t;

    stim_t        stim_q[$];
    logic [W-1:0] exp_q[$];
    vec_t         tbl[5];
    int           checks = 0;
    int           errors = 0;
    logic         model_err;

    mips_multicycle_sequencer #(
        .MULDIV_LATENCY(MD_LAT),
        .TIMEOUT_CYCLES(TMO),
        .STATE_W       (3)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .waitrequest  (waitrequest),
        .pc_zero      (pc_zero),
        .is_load      (is_load),
        .is_store     (is_store),
        .is_muldiv    (is_muldiv),
        .state        (state),
        .active       (active),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_src      (mem_src),
        .ir_load      (ir_load),
        .cnt_en       (cnt_en),
        .wb_en        (wb_en),
        .muldiv_start (muldiv_start),
        .muldiv_busy  (muldiv_busy),
        .bus_err      (bus_err)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: builds the expected per-cycle trace of each instruction
    // from its class and the number of stall cycles in each memory phase.
    function automatic out_t mk(logic [2:0] st, logic rd, logic wt, logic src, logic ir,
                                logic cnt, logic wb, logic mds, logic mdb);
        out_t o;
        o.st  = st;
        o.act = !(st == S_IDLE || st == S_HALT);
        o.rd  = rd;
        o.wt  = wt;
        o.src = src;
        o.ir  = ir;
        o.cnt = cnt;
        o.wb  = wb;
        o.mds = mds;
        o.mdb = mdb;
        o.err = model_err;
        return o;
    endfunction

    function automatic stim_t rnd_stim();
        logic [4:0] r;
        stim_t      s;
        r = 5'($urandom_range(0, 31));
        s = r;
        return s;
    endfunction

    function automatic void push(stim_t s, out_t o);
        stim_q.push_back(s);
        exp_q.push_back(o);
    endfunction

    function automatic void begin_prog();
        model_err = 1'b0;
        push(rnd_stim(), mk(S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0));
    endfunction

    function automatic void halt_tail(int n);
        for (int i = 0; i < n; i++) push(rnd_stim(), mk(S_HALT, 0, 0, 0, 0, 0, 0, 0, 0));
    endfunction

    // One memory access with 'waits' stalled cycles; returns 1 if it times out.
    function automatic bit mem_phase(logic [2:0] st, logic rd, logic wt, logic src, int waits,
                                     logic ir_done, logic cnt_done, stim_t base);
        stim_t s;
        for (int i = 0; i < waits && i < TMO; i++) begin
            s    = base;
            s.wr = 1'b1;
            push(s, mk(st, rd, wt, src, 0, 0, 0, 0, 0));
        end
        if (waits >= TMO) begin
            model_err = 1'b1;
            return 1'b1;
        end
        s    = base;
        s.wr = 1'b0;
        push(s, mk(st, rd, wt, src, ir_done, cnt_done, 0, 0, 0));
        return 1'b0;
    endfunction

    // kind: 0 ALU, 1 load, 2 store, 3 muldiv. Returns 1 if the bus timed out.
    function automatic bit gen_instr(int kind, int fw, int ew);
        stim_t b;
        b    = rnd_stim();
        b.pz = 1'b0;
        if (mem_phase(S_FETCH, 1, 0, 1, fw, 1, 0, b)) return 1'b1;
        b = rnd_stim();
        case (kind)
            0: begin
                b.ld = 1'b0; b.st = 1'b0; b.md = 1'b0;
                push(b, mk(S_EXEC1, 0, 0, 0, 0, 1, 0, 0, 0));
            end
            1: begin
                b.ld = 1'b1;
                if (mem_phase(S_EXEC1, 1, 0, 0, ew, 0, 0, b)) return 1'b1;
                push(rnd_stim(), mk(S_EXEC2, 0, 0, 0, 0, 1, 1, 0, 0));
            end
            2: begin
                b.ld = 1'b0; b.st = 1'b1;
                if (mem_phase(S_EXEC1, 0, 1, 0, ew, 0, 1, b)) return 1'b1;
            end
            default: begin
                b.ld = 1'b0; b.st = 1'b0; b.md = 1'b1;
                push(b, mk(S_EXEC1, 0, 0, 0, 0, 0, 0, 1, 0));
                for (int i = 0; i < MD_LAT; i++)
                    push(rnd_stim(), mk(S_MDWAIT, 0, 0, 0, 0, (i == MD_LAT - 1), 0, 0, 1));
            end
        endcase
        return 1'b0;
    endfunction

    function automatic void gen_pc_zero();
        stim_t b;
        b    = rnd_stim();
        b.pz = 1'b1;
        push(b, mk(S_FETCH, 0, 0, 0, 0, 0, 0, 0, 0));
        halt_tail(3);
    endfunction

    function automatic int pick_waits();
        if ($urandom_range(0, 9) == 9) return int'($urandom_range(6, 10));
        return int'($urandom_range(0, 3));
    endfunction

    // Driver and checker
    task automatic drive(input stim_t s);
        waitrequest = s.wr;
        pc_zero     = s.pz;
        is_load     = s.ld;
        is_store    = s.st;
        is_muldiv   = s.md;
    endtask

    function automatic out_t sample();
        out_t a;
        a.st  = state;
        a.act = active;
        a.rd  = mem_read;
        a.wt  = mem_write;
        a.src = mem_src;
        a.ir  = ir_load;
        a.cnt = cnt_en;
        a.wb  = wb_en;
        a.mds = muldiv_start;
        a.mdb = muldiv_busy;
        a.err = bus_err;
        return a;
    endfunction

    task automatic check_out(input string name, input out_t e);
        out_t a;
        a = sample();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got st=%0d bits=%b, expected st=%0d bits=%b",
                     name, a.st, a[9:0], e.st, e[9:0]);
        end
    endtask

    // Plays the queued trace (all of it when n < 0), releasing reset on the first cycle.
    task automatic run_trace(input string name, input int n);
        int k;
        k = 0;
        while (stim_q.size() != 0 && (n < 0 || k < n)) begin
            stim_t s;
            out_t  e;
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            @(negedge clk);
            reset_n = 1'b1;
            drive(s);
            #1;
            check_out($sformatf("%s[%0d]", name, k), e);
            k++;
        end
        stim_q.delete();
        exp_q.delete();
    endtask

    // Asserts reset between clock edges; outputs must clear without a clock.
    task automatic assert_reset(input string name);
        #1;
        reset_n = 1'b0;
        #1;
        check_out(name, '0);
    endtask

    initial begin
        stim_t s0;
        reset_n   = 1'b0;
        s0        = '0;
        drive(s0);
        model_err = 1'b0;

        tbl[0].s = 5'b00000; tbl[0].o = mk(S_IDLE,  0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1].s = 5'b00000; tbl[1].o = mk(S_FETCH, 1, 0, 1, 1, 0, 0, 0, 0);
        tbl[2].s = 5'b10000; tbl[2].o = mk(S_EXEC1, 0, 0, 0, 0, 1, 0, 0, 0);
        tbl[3].s = 5'b10000; tbl[3].o = mk(S_FETCH, 1, 0, 1, 0, 0, 0, 0, 0);
        tbl[4].s = 5'b00000; tbl[4].o = mk(S_FETCH, 1, 0, 1, 1, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        #1;
        check_out("reset_state", '0);

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            reset_n = 1'b1;
            drive(tbl[i].s);
            #1;
            check_out($sformatf("alu_tbl[%0d]", i), tbl[i].o);
        end
        assert_reset("rst_after_alu");

        begin_prog(); void'(gen_instr(1, 3, 2)); void'(gen_instr(0, 0, 0));
        run_trace("load_3_2", -1);
        assert_reset("rst_after_load");

        begin_prog(); void'(gen_instr(3, 0, 0)); void'(gen_instr(0, 0, 0));
        run_trace("muldiv", -1);
        assert_reset("rst_after_muldiv");

        begin_prog(); void'(gen_instr(2, 0, TMO - 1)); void'(gen_instr(2, 1, 0));
        run_trace("store_below_timeout", -1);
        assert_reset("rst_after_store");

        begin_prog(); if (gen_instr(2, 0, 20)) halt_tail(20);
        run_trace("store_timeout", -1);
        assert_reset("rst_clears_bus_err");

        begin_prog(); if (gen_instr(0, TMO, 0)) halt_tail(5);
        run_trace("fetch_timeout", -1);
        assert_reset("rst_after_fetch_timeout");

        begin_prog(); void'(gen_instr(0, 1, 0)); gen_pc_zero();
        run_trace("pc_zero", -1);
        assert_reset("rst_after_pc_zero");

        begin_prog(); void'(gen_instr(1, 1, 5));
        run_trace("stalled_load", 5);
        assert_reset("async_rst_load");

        begin_prog(); void'(gen_instr(0, 0, 0));
        run_trace("after_rst_load", -1);
        assert_reset("rst_after_restart");

        begin_prog(); void'(gen_instr(3, 0, 0));
        run_trace("mdwait_abort", 5);
        assert_reset("async_rst_mdwait");

        begin_prog(); void'(gen_instr(3, 0, 0));
        run_trace("after_rst_mdwait", -1);
        assert_reset("rst_after_mdwait_restart");

        for (int p = 0; p < 40; p++) begin
            int n;
            begin_prog();
            n = int'($urandom_range(1, 5));
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(0, 19) == 0) begin
                    gen_pc_zero();
                    break;
                end
                if (gen_instr(int'($urandom_range(0, 3)), pick_waits(), pick_waits())) begin
                    halt_tail(3);
                    break;
                end
            end
            run_trace($sformatf("rand%0d", p), -1);
            assert_reset($sformatf("rand_rst%0d", p));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
